// File: rtl/data_memory_mmio.sv
// Word-addressed data memory with a small memory-mapped I/O window.
// Loads are registered (one-cycle latency); stores to the MMIO window drive output channels.
module data_memory_mmio #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 1024,
  parameter int                MMIO_BASE = 'hFF00,
  parameter int                MMIO_CH   = 4,
  parameter logic [DATA_W-1:0] MMIO_RST  = 16'h0002
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           write_data,
  input  logic                        mem_read,
  input  logic                        mem_write,
  output logic [DATA_W-1:0]           read_data,
  output logic                        read_valid,
  output logic [MMIO_CH*DATA_W-1:0]   mmio_out,
  output logic [MMIO_CH-1:0]          mmio_strobe,
  input  logic [MMIO_CH*DATA_W-1:0]   mmio_in,
  input  logic                        err_clear,
  output logic                        access_err
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so the top of the address space compares without wrapping.
  localparam logic [ADDR_W:0] RAM_END  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] OUT_BASE = (ADDR_W+1)'(MMIO_BASE);
  localparam logic [ADDR_W:0] IN_BASE  = (ADDR_W+1)'(MMIO_BASE + MMIO_CH);

  logic [DATA_W-1:0]              mem [DEPTH];
  logic [MMIO_CH-1:0][DATA_W-1:0] mmio_reg;
  logic [MMIO_CH-1:0][DATA_W-1:0] sync1;
  logic [MMIO_CH-1:0][DATA_W-1:0] sync2;

  logic [ADDR_W:0]    addr_ext;
  logic [RAM_AW-1:0]  ram_idx;
  logic               is_ram;
  logic [MMIO_CH-1:0] out_hit;
  logic [MMIO_CH-1:0] in_hit;
  logic               unmapped;
  logic               bad_access;
  logic [DATA_W-1:0]  mmio_word;

  assign addr_ext   = {1'b0, address};
  assign ram_idx    = address[RAM_AW-1:0];
  assign is_ram     = (addr_ext < RAM_END);
  assign unmapped   = !(is_ram || (|out_hit) || (|in_hit));
  assign bad_access = (mem_write && (unmapped || (|in_hit))) || (mem_read && unmapped);
  assign mmio_out   = mmio_reg;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    out_hit   = '0;
    in_hit    = '0;
    mmio_word = '0;
    for (int i = 0; i < MMIO_CH; i++) begin
      out_hit[i] = (addr_ext == OUT_BASE + (ADDR_W+1)'(i));
      in_hit[i]  = (addr_ext == IN_BASE + (ADDR_W+1)'(i));
      if (out_hit[i]) mmio_word = mmio_reg[i];
      if (in_hit[i])  mmio_word = sync2[i];
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM and keeps its contents across rst; stores are still blocked while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && mem_write && is_ram) mem[ram_idx] <= write_data;
  end

  // NOTE: all state below uses non-blocking assignments, so a same-edge read sees the pre-write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data   <= '0;
      read_valid  <= 1'b0;
      mmio_reg    <= {MMIO_CH{MMIO_RST}};
      mmio_strobe <= '0;
      sync1       <= '0;
      sync2       <= '0;
      access_err  <= 1'b0;
    end else begin
      sync1       <= mmio_in;
      sync2       <= sync1;
      read_valid  <= mem_read;
      mmio_strobe <= mem_write ? out_hit : '0;
      if (mem_read) read_data <= is_ram ? mem[ram_idx] : mmio_word;
      for (int i = 0; i < MMIO_CH; i++) begin
        if (mem_write && out_hit[i]) mmio_reg[i] <= write_data;
      end
      // Set wins over clear so an error in the clearing cycle is not lost.
      if (bad_access)     access_err <= 1'b1;
      else if (err_clear) access_err <= 1'b0;
    end
  end

endmodule
